// File: rtl/mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mult_ctrl
//  Purpose  : Sequential radix-2 Booth signed multiplier with start/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int               CNT_W       = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_upper;
  logic [WIDTH-1:0] r_lower;
  logic             r_qm1;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;

  logic [WIDTH:0]   w_upperExt;
  logic [WIDTH:0]   w_mcandExt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_shUpper;
  logic [WIDTH-1:0] w_shLower;
  logic             w_start;
  logic             w_lastStep;
  logic             w_excpt;

  // One extra sign bit keeps the add/subtract exact even for the most negative multiplicand.
  always_comb begin
    w_upperExt = {r_upper[WIDTH-1], r_upper};
    w_mcandExt = {r_mcand[WIDTH-1], r_mcand};
    case ({r_lower[0], r_qm1})
      2'b10:   w_sum = w_upperExt - w_mcandExt;
      2'b01:   w_sum = w_upperExt + w_mcandExt;
      default: w_sum = w_upperExt;
    endcase
    w_shUpper  = w_sum[WIDTH:1];
    w_shLower  = {w_sum[0], r_lower[WIDTH-1:1]};
    w_excpt    = !((&{w_shUpper, w_shLower[WIDTH-1]}) || !(|{w_shUpper, w_shLower[WIDTH-1]}));
    w_start    = (r_state == IDLE) && ctrl_MULT;
    w_lastStep = (r_state == RUN) && (r_count == C_LAST_STEP);
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (ctrl_MULT) w_nextState = RUN;
      RUN:     if (w_lastStep) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mcand     <= '0;
      r_upper     <= '0;
      r_lower     <= '0;
      r_qm1       <= 1'b0;
      r_count     <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
    end else if (w_start) begin
      r_mcand <= data_operandA;
      r_upper <= '0;
      r_lower <= data_operandB;
      r_qm1   <= 1'b0;
      r_count <= '0;
    end else if (r_state == RUN) begin
      r_upper <= w_shUpper;
      r_lower <= w_shLower;
      r_qm1   <= r_lower[0];
      r_count <= r_count + 1'b1;
      // Result registers only move on the final step so they hold through later runs.
      if (w_lastStep) begin
        r_result    <= w_shLower;
        r_exception <= w_excpt;
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = (r_state == DONE);
  assign busy           = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_ctrl
//  Purpose  : Randomized and directed bench for mult_ctrl against a product model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_ctrl;

  localparam int    W    = 32;
  localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (W - 1));

  logic         clock    = 1'b0;
  logic         reset    = 1'b1;
  logic         ctrlMult = 1'b0;
  logic [W-1:0] opA      = '0;
  logic [W-1:0] opB      = '0;
  logic [W-1:0] result;
  logic         exception;
  logic         rdy;
  logic         busy;

  int total = 0;
  int bad   = 0;

  mult_ctrl #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrlMult),
    .data_operandA  (opA),
    .data_operandB  (opB),
    .data_result    (result),
    .data_exception (exception),
    .data_resultRDY (rdy),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic checkWord(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic signed [2*W-1:0] refProd(input logic [W-1:0] a, input logic [W-1:0] b);
    return $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
  endfunction

  function automatic logic refExc(input logic signed [2*W-1:0] p);
    return (p > MAXV) || (p < MINV);
  endfunction

  // Model: age counts edges since the accepted start (-1 when idle).
  int                      age      = -1;
  logic signed [2*W-1:0]   pendProd = '0;
  logic [W-1:0]            expRes   = '0;
  logic                    expExc   = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      age    = -1;
      expRes = '0;
      expExc = 1'b0;
    end else if (age < 0) begin
      if (ctrlMult) begin
        age      = 0;
        pendProd = refProd(opA, opB);
      end
    end else begin
      age++;
      if (age == W) begin
        expRes = pendProd[W-1:0];
        expExc = refExc(pendProd);
      end else if (age > W) begin
        age = -1;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    checkBit("busy", busy, age >= 0);
    checkBit("rdy", rdy, age == W);
    checkWord("result", result, expRes);
    checkBit("exception", exception, expExc);
  end

  task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b);
    opA      = a;
    opB      = b;
    ctrlMult = 1'b1;
    @(negedge clock);
    ctrlMult = 1'b0;
    opA      = $urandom;
    opB      = $urandom;
  endtask

  task automatic waitRdy(input string name, output int n);
    n = 0;
    while (!rdy && n < 3 * W) begin
      @(negedge clock);
      n++;
    end
    checkBit({name, " rdy seen"}, rdy, 1'b1);
  endtask

  task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] expR, input logic expE);
    int n;
    startOp(a, b);
    waitRdy(name, n);
    checkWord({name, " result"}, result, expR);
    checkBit({name, " exception"}, exception, expE);
    checkWord({name, " latency"}, W'(n + 1), W'(W + 1));
    @(negedge clock);
    checkBit({name, " busy after"}, busy, 1'b0);
    checkBit({name, " rdy after"}, rdy, 1'b0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0:       v = {1'b1, {(W-1){1'b0}}};
      1:       v = '1;
      2:       v = '0;
      3:       v = W'(1);
      4:       v = W'($urandom_range(0, 65535));
      5:       v = -W'($urandom_range(0, 65535));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int n;
    int pulses;
    repeat (3) @(negedge clock);
    checkWord("reset result", result, '0);
    checkBit("reset exception", exception, 1'b0);
    checkBit("reset rdy", rdy, 1'b0);
    checkBit("reset busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    runOp("3x4", 32'd3, 32'd4, 32'h0000000C, 1'b0);
    runOp("m7x6", 32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0);
    runOp("minx1", 32'h80000000, 32'd1, 32'h80000000, 1'b0);
    runOp("ovf16", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    runOp("minxm1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);

    // A second start mid-run must be ignored.
    startOp(32'd5, 32'd5);
    repeat (9) @(negedge clock);
    opA = 32'd9; opB = 32'd9; ctrlMult = 1'b1;
    @(negedge clock);
    ctrlMult = 1'b0;
    checkWord("held result", result, 32'h80000000);
    waitRdy("ignore", n);
    checkWord("ignore result", result, 32'h00000019);
    pulses = 0;
    repeat (W + 4) begin
      @(negedge clock);
      if (rdy) pulses++;
    end
    checkWord("ignore extra pulses", W'(pulses), '0);

    // Reset mid-run aborts without a ready pulse.
    startOp(32'd2, 32'd3);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    checkWord("abort result", result, '0);
    checkBit("abort exception", exception, 1'b0);
    checkBit("abort rdy", rdy, 1'b0);
    checkBit("abort busy", busy, 1'b0);
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    pulses = 0;
    repeat (W + 4) begin
      @(negedge clock);
      if (rdy) pulses++;
    end
    checkWord("abort pulses", W'(pulses), '0);
    runOp("2x3", 32'd2, 32'd3, 32'h00000006, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      ctrlMult = ($urandom_range(0, 5) == 0);
      opA      = pick();
      opB      = pick();
      @(negedge clock);
    end
    ctrlMult = 1'b0;
    n = 0;
    while (busy && n < 3 * W) begin
      @(negedge clock);
      n++;
    end
    checkBit("drain busy", busy, 1'b0);

    // Start held high: back-to-back operations.
    ctrlMult = 1'b1;
    pulses   = 0;
    repeat (3 * W + 8) begin
      opA = pick();
      opB = pick();
      @(negedge clock);
      if (rdy) pulses++;
    end
    ctrlMult = 1'b0;
    checkWord("held-high pulses", W'(pulses), W'(3));
    repeat (W + 4) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
